// File: rtl/riscv_pkg.sv
// Shared RV32 core types and constants.
// Fetch stage entries pair a word with the address it was fetched from.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a flush that discards contents and wins over same-cycle push/pop.
// Head data comes straight from storage, so a pushed word is visible the next cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// RV32 instruction fetch: credit-limited word requests, in-order responses,
// buffered {pc, instr} delivery to decode, redirect with stale-response dropping.
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pcplus4,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_fault
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int EW = $bits(fetch_entry_t);
    localparam logic [CW+1:0] DEPTH_W = (CW+2)'(BUF_DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic            fault;

    logic [CW-1:0]   occupancy;
    logic            buf_empty;
    logic [EW-1:0]   buf_rdata;
    fetch_entry_t    buf_head;
    fetch_entry_t    buf_wentry;

    logic [XLEN-1:0] pcq_head;
    logic            pcq_empty;
    logic [CW-1:0]   pcq_count;

    logic [CW+1:0]   committed;
    logic            req_accept;
    logic            rsp_drop;
    logic            rsp_take;
    logic            head_pop;

    // Every entry that will eventually land in the buffer (or be thrown away)
    // holds a credit, so the buffer can never be pushed while full.
    assign committed = (CW+2)'(occupancy) + (CW+2)'(outstanding) + (CW+2)'(drop);

    assign imem_req_valid = !reset && !fault && !redirect_valid && (committed < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_accept     = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop != '0);
    assign rsp_take = imem_rsp_valid && (drop == '0) && (outstanding != '0);

    assign buf_head      = fetch_entry_t'(buf_rdata);
    assign instr_valid   = !buf_empty;
    assign head_pop      = instr_valid && instr_ready;
    assign instr         = instr_valid ? buf_head.instr : '0;
    assign instr_pc      = instr_valid ? buf_head.pc : '0;
    assign instr_pcplus4 = instr_pc + 32'd4;
    assign fetch_fault   = fault;

    assign buf_wentry.pc    = pcq_head;
    assign buf_wentry.instr = imem_rsp_data;

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_pcq (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (req_accept),
        .wdata (fetch_pc),
        .pop   (rsp_take),
        .rdata (pcq_head),
        .empty (pcq_empty),
        .count (pcq_count)
    );

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (rsp_take),
        .wdata (buf_wentry),
        .pop   (head_pop),
        .rdata (buf_rdata),
        .empty (buf_empty),
        .count (occupancy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            fault       <= 1'b0;
        end else if (redirect_valid) begin
            // Everything still in flight becomes a response to discard.
            fetch_pc    <= word_align(redirect_pc);
            drop        <= drop - CW'(rsp_drop) + outstanding - CW'(rsp_take);
            outstanding <= '0;
            if (redirect_pc[1:0] != 2'b00) begin
                fault <= 1'b1;
            end
        end else begin
            if (req_accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(req_accept) - CW'(rsp_take);
            drop        <= drop - CW'(rsp_drop);
        end
    end

    a_rsp_expected: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> ((outstanding != '0) || (drop != '0)));

    a_pcq_tracks: assert property (@(posedge clk) disable iff (reset)
        (pcq_count == outstanding) && (pcq_empty == (outstanding == '0)));

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: behavioural memory with selectable latency,
// scoreboard of expected {pc, instr} filled on request accept, checked on decode pop.
module tb_ifetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    ifetch_unit #(
        .RESET_PC  (RPC),
        .BUF_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pcplus4  (instr_pcplus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    fetch_entry_t sbq[$];
    mreq_t        memq[$];
    logic [31:0]  hist[$];
    logic [31:0]  acc_hist[$];
    logic [31:0]  model_pc    = RPC;
    logic         model_fault = 1'b0;
    int           cyc       = 0;
    int           acc_cnt   = 0;
    int           pop_cnt   = 0;
    int           first_acc = -1;
    int           first_vld = -1;
    int           mem_lat   = 1;

    // Memory model and scoreboard: observe mid-cycle, drive responses just after the edge.
    initial begin
        logic         nrv;
        logic [31:0]  nrd;
        fetch_entry_t e;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            nrv = 1'b0;
            nrd = '0;
            if (reset) begin
                sbq.delete();
                memq.delete();
                hist.delete();
                acc_hist.delete();
                model_pc    = RPC;
                model_fault = 1'b0;
                acc_cnt     = 0;
                pop_cnt     = 0;
                first_acc   = -1;
                first_vld   = -1;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    memq.push_back('{addr: imem_req_addr, due: cyc + mem_lat - 1});
                    acc_hist.push_back(imem_req_addr);
                    acc_cnt++;
                    if (first_acc < 0) first_acc = cyc;
                end
                if (memq.size() > 0 && memq[0].due <= cyc) begin
                    nrv = 1'b1;
                    nrd = memdata(memq[0].addr);
                    void'(memq.pop_front());
                end
                if (redirect_valid) begin
                    chk("req_in_redirect", {31'b0, imem_req_valid}, 32'd0);
                    sbq.delete();
                    hist.delete();
                    model_pc = {redirect_pc[31:2], 2'b00};
                    if (redirect_pc[1:0] != 2'b00) model_fault = 1'b1;
                end else begin
                    if (instr_valid && instr_ready) begin
                        if (sbq.size() == 0) begin
                            chk("stale_instr_valid", {31'b0, instr_valid}, 32'd0);
                        end else begin
                            e = sbq.pop_front();
                            chk("instr_pc", instr_pc, e.pc);
                            chk("instr", instr, e.instr);
                            chk("instr_pcplus4", instr_pcplus4, e.pc + 32'd4);
                        end
                        hist.push_back(instr_pc);
                        pop_cnt++;
                        if (first_vld < 0) first_vld = cyc;
                    end
                    if (imem_req_valid && imem_req_ready) begin
                        chk("req_addr", imem_req_addr, model_pc);
                        if (model_fault) chk("req_while_fault", {31'b0, imem_req_valid}, 32'd0);
                        sbq.push_back('{pc: model_pc, instr: memdata(model_pc)});
                        model_pc = model_pc + 32'd4;
                    end
                end
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = nrv;
            imem_rsp_data  = nrd;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat, input logic rdy);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step();
        step();
        mem_lat     = lat;
        instr_ready = rdy;
        reset       = 1'b0;
    endtask

    typedef struct {
        int          lat;
        logic        rdy;
        int          stall;
        logic [31:0] target;
        logic [31:0] exp_first;
    } vec_t;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        vec_t tv[5];
        int   p0;
        tv[0] = '{3, 1'b1, 4, 32'h0000_2000, 32'h0000_2000};
        tv[1] = '{1, 1'b1, 5, 32'h0000_2000, 32'h0000_2000};
        tv[2] = '{1, 1'b0, 6, 32'h0000_3000, 32'h0000_3000};
        tv[3] = '{2, 1'b1, 3, 32'hFFFF_FFF8, 32'hFFFF_FFF8};
        tv[4] = '{1, 1'b1, 0, 32'h0000_4000, 32'h0000_4000};

        reset          = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step();
        step();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_pcplus4", instr_pcplus4, 32'd4);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);

        // Streaming: latency and one instruction per cycle.
        reset = 1'b0;
        repeat (10) step();
        p0 = pop_cnt;
        repeat (20) step();
        chk("first_latency", 32'(first_vld - first_acc), 32'd2);
        chk("throughput", 32'(pop_cnt - p0), 32'd20);
        if (hist.size() > 0) chk("first_pc", hist[0], RPC);

        // Decode stalled: credit stops at buffer depth, then resumes in order.
        do_reset(1, 1'b0);
        repeat (20) step();
        chk("stall_accepts", 32'(acc_cnt), 32'd4);
        chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("stall_instr_valid", {31'b0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        repeat (20) step();
        chk("resume_len", {31'b0, acc_hist.size() > 4}, 32'd1);
        if (acc_hist.size() > 4) chk("resume_addr", acc_hist[4], 32'h0000_1010);

        // Redirect scenarios.
        for (int i = 0; i < 5; i++) begin
            do_reset(tv[i].lat, tv[i].rdy);
            repeat (tv[i].stall) step();
            redirect_pc    = tv[i].target;
            redirect_valid = 1'b1;
            step();
            redirect_valid = 1'b0;
            instr_ready    = 1'b1;
            repeat (15) step();
            chk("redir_hist_len", {31'b0, hist.size() >= 3}, 32'd1);
            if (hist.size() >= 3) begin
                for (int k = 0; k < 3; k++) begin
                    chk("redir_pc_seq", hist[k], tv[i].exp_first + 32'(4 * k));
                end
            end
            chk("redir_fault", {31'b0, fetch_fault}, 32'd0);
        end

        // Back-to-back redirects while responses are still being dropped.
        do_reset(3, 1'b1);
        repeat (4) step();
        redirect_pc = 32'h0000_5000;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        step();
        redirect_pc = 32'h0000_6000;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        repeat (20) step();
        chk("dbl_hist_len", {31'b0, hist.size() > 0}, 32'd1);
        if (hist.size() > 0) chk("dbl_first_pc", hist[0], 32'h0000_6000);

        // Misaligned redirect: sticky fault, then async reset recovery.
        do_reset(1, 1'b1);
        repeat (5) step();
        redirect_pc    = 32'h0000_2002;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 4; k++) begin
            repeat (3) step();
            chk("fault_set", {31'b0, fetch_fault}, 32'd1);
            chk("fault_req_valid", {31'b0, imem_req_valid}, 32'd0);
            chk("fault_instr_valid", {31'b0, instr_valid}, 32'd0);
        end
        #2;
        reset = 1'b1;
        #1;
        chk("fault_async_clear", {31'b0, fetch_fault}, 32'd0);
        step();
        step();
        reset = 1'b0;
        repeat (10) step();
        chk("fault_restart_len", {31'b0, acc_hist.size() > 0}, 32'd1);
        if (acc_hist.size() > 0) chk("fault_restart_addr", acc_hist[0], RPC);

        // Reset mid-stream clears outputs asynchronously.
        do_reset(1, 1'b1);
        repeat (10) step();
        chk("pre_reset_valid", {31'b0, instr_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("async_instr_pc", instr_pc, 32'd0);
        chk("async_pcplus4", instr_pcplus4, 32'd4);
        chk("async_req_valid", {31'b0, imem_req_valid}, 32'd0);
        step();
        step();
        reset = 1'b0;
        repeat (10) step();
        chk("post_reset_stream", {31'b0, pop_cnt > 5}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage for the RV32 core. Owns the fetch PC, issues word requests to instruction memory over a valid/ready request channel, and receives in-order responses.
- Buffers fetched words with their PCs and presents them to decode. Decode feeds instr[31:7] to the immediate extender.
- Accepts a redirect, the branch/jump target built from PC + extended immediate, and flushes stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned.
- BUF_DEPTH, 4, instruction buffer entries and max in-flight credit; power of 2, ≥2.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response valid, in request order, max one per cycle
- imem_rsp_data  in  32  instruction word
- instr_valid  out  1  buffer head valid
- instr_ready  in  1  decode consumes head
- instr  out  32  head instruction; instr[31:7] goes to the extender
- instr_pc  out  32  PC of head
- instr_pcplus4  out  32  instr_pc + 4
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  32  new fetch target
- fetch_fault  out  1  sticky misaligned-redirect flag

Behaviour:
- Reset, asynchronous: fetch_pc=RESET_PC, buffer empty, outstanding=0, drop=0, fetch_fault=0. Outputs during reset: imem_req_valid=0, instr_valid=0, instr/instr_pc=0, instr_pcplus4=4. Instruction memory is reset with the core; no pre-reset responses arrive.
- Credit:
  - imem_req_valid = !fetch_fault && !redirect_valid && (occupancy + outstanding + drop < BUF_DEPTH).
  - imem_req_addr = fetch_pc.
- Request accept (valid & ready): fetch_pc += 4, modulo 2^32, so 0xFFFF_FFFC wraps to 0x0. The address is pushed to an in-flight PC queue and outstanding++.
- Response:
  - If drop>0: discard the response, drop--.
  - Otherwise: pop the PC queue and push {pc, data} into the buffer, outstanding--.
  - Request accept and response in the same cycle: counters net correctly.
  - A response with outstanding+drop==0 is a protocol error. Ignore it and flag it with a sim assertion.
- Output timing:
  - Buffer is registered; the head is visible the cycle after push.
  - Latency from request accept to instr_valid is 2 cycles with 1-cycle memory.
  - BUF_DEPTH=4 sustains 1 instr/cycle.
- Pop on instr_valid & instr_ready. Simultaneous push and pop is legal. Credit guarantees no push into a full buffer.
- Redirect (redirect_valid=1), applied at the clock edge:
  - Buffer flushed; a same-cycle pop or push is discarded.
  - drop = outstanding, minus 1 if a non-dropped response arrives that cycle; in-flight PC queue cleared; outstanding=0.
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - No request is issued in the redirect cycle. The first request to the new target is issued the next cycle.
- Misaligned redirect (redirect_pc[1:0]!=0): flush as above and set fetch_fault=1. fetch_fault holds until reset and blocks all further requests. Buffered entries are already flushed.
- Redirect while drop>0: the new outstanding count adds to the existing drop.
- Counter widths are $clog2(BUF_DEPTH)+1. No counter exceeds BUF_DEPTH.

Decomposition:
- Shared package riscv_pkg:
  - XLEN=32, ILEN=32.
  - fetch_entry_t struct {pc, instr}.
  - NOP constant 32'h0000_0013.
- One sub-module: fetch_fifo, a synchronous FIFO of fetch_entry_t with flush, reused for the in-flight PC queue at width 32.

Test Plan:
- RESET_PC=0x1000, memory always ready, 1-cycle latency, instr_ready=1 → instr_pc 0x1000, 0x1004, 0x1008… on consecutive cycles; first instr_valid 2 cycles after the first request accept.
- instr_ready=0 throughout → exactly 4 requests accepted, then imem_req_valid=0; raising instr_ready resumes with addr 0x1010 and in-order delivery.
- Redirect to 0x2000 with 2 requests outstanding → both responses discarded; the next instr_pc is 0x2000 with the correct data; no stale instr_valid.
- Redirect asserted in the same cycle as a head pop and a response arrival → buffer empty next cycle; following instr_pc sequence 0x2000, 0x2004; no duplicated or missing PCs.
- Redirect to 0x2002 → fetch_fault=1 and imem_req_valid stays 0 indefinitely; async reset clears the fault and restarts at RESET_PC.
- Redirect to 0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; reset asserted mid-stream forces instr_valid=0 immediately, asynchronously.
